ram_arbiter: RTL

Two-port front end for the team's single-port block RAM: arbitrates between the core's instruction-fetch port and load/store port and drives the RAM's enable, byte-write, address and write-data inputs. It registers read data back to the winning requester and turns byte-lane writes the RAM cannot perform natively into read-modify-write sequences. It sits between the core and the RAM, one per RAM instance.

---
 rtl/ram_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port (instruction fetch / load-store) front end for a single-port
// block RAM. Arbitrates round-robin under contention, registers read data
// back to the winning port, and turns byte-lane writes the RAM cannot do
// natively into a read-modify-write pair of cycles.
//
// Handshake: a requester raises req with stable addr/we/be/wdata and holds
// them until it sees gnt in the same cycle; exactly one rvalid pulse follows
// each grant on that port (1 cycle later, 2 for read-modify-write) and
// results are never queued, so there is no back-pressure.
module ram_arbiter #(
    parameter int RAM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_gnt_o,
    output logic        i_rvalid_o,
    output logic [31:0] i_rdata_o,
    output logic        i_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic        ram_en_o,
    output logic [3:0]  ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_din_o,
    input  logic [31:0] ram_dout_i,
    output logic        dbg_state_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        rr_q;          // 0: instruction port wins the next tie
    logic        i_sel, d_sel;
    logic        i_oor, d_oor;
    logic        d_native, d_rmw;
    logic [31:0] merge_w;
    logic [31:0] merged_q, merged_d;
    logic [29:0] rmw_word_q;
    logic        unused_addr_lsbs;

    // Byte offsets are ignored: the RAM is word addressed.
    assign unused_addr_lsbs = ^{i_addr_i[1:0], d_addr_i[1:0]};

    assign i_oor    = {2'b00, i_addr_i[31:2]} >= 32'(RAM_WORDS);
    assign d_oor    = {2'b00, d_addr_i[31:2]} >= 32'(RAM_WORDS);
    assign d_native = (d_be_i == 4'b1111) || (d_be_i == 4'b0011) || (d_be_i == 4'b0001);
    assign d_rmw    = d_we_i && !d_oor && (d_be_i != 4'b0000) && !d_native;

    assign i_gnt_o     = i_sel;
    assign d_gnt_o     = d_sel;
    assign dbg_state_o = (state_q == ST_RMW);

    // Lane merge of new write data over the word currently read from the RAM.
    always_comb begin
        merge_w = ram_dout_i;
        for (int b = 0; b < 4; b++) begin
            if (d_be_i[b]) merge_w[8*b +: 8] = d_wdata_i[8*b +: 8];
        end
    end

    // Arbitration, RAM port drive and next-state selection.
    always_comb begin
        state_d    = state_q;
        merged_d   = merged_q;
        i_sel      = 1'b0;
        d_sel      = 1'b0;
        ram_en_o   = 1'b0;
        ram_we_o   = 4'b0000;
        ram_addr_o = 32'h0;
        ram_din_o  = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (i_req_i && d_req_i) begin
                    i_sel = !rr_q;
                    d_sel = rr_q;
                end else begin
                    i_sel = i_req_i;
                    d_sel = d_req_i;
                end
                if (i_sel && !i_oor) begin
                    ram_en_o   = 1'b1;
                    ram_addr_o = {i_addr_i[31:2], 2'b00};
                end
                if (d_sel && !d_oor) begin
                    ram_addr_o = {d_addr_i[31:2], 2'b00};
                    if (!d_we_i) begin
                        ram_en_o = 1'b1;
                    end else if (d_native) begin
                        ram_en_o  = 1'b1;
                        ram_we_o  = d_be_i;
                        ram_din_o = d_wdata_i;
                    end else if (d_rmw) begin
                        // Read phase: capture the merged word, write it next cycle.
                        ram_en_o = 1'b1;
                        merged_d = merge_w;
                        state_d  = ST_RMW;
                    end
                end
            end
            ST_RMW: begin
                ram_en_o   = 1'b1;
                ram_we_o   = 4'b1111;
                ram_addr_o = {rmw_word_q, 2'b00};
                ram_din_o  = merged_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, round-robin pointer and read-modify-write context.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rr_q       <= 1'b0;
            merged_q   <= 32'h0;
            rmw_word_q <= 30'h0;
        end else begin
            state_q  <= state_d;
            merged_q <= merged_d;
            if (d_sel && d_rmw) rmw_word_q <= d_addr_i[31:2];
            if ((state_q == ST_IDLE) && i_req_i && d_req_i) rr_q <= !rr_q;
        end
    end

    // Registered responses; a write (direct, no-op or merged) acks with zero data.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            i_rvalid_o <= 1'b0;
            i_rdata_o  <= 32'h0;
            i_err_o    <= 1'b0;
            d_rvalid_o <= 1'b0;
            d_rdata_o  <= 32'h0;
            d_err_o    <= 1'b0;
        end else begin
            i_rvalid_o <= i_sel;
            i_err_o    <= i_sel && i_oor;
            i_rdata_o  <= (i_sel && !i_oor) ? ram_dout_i : 32'h0;
            d_rvalid_o <= (d_sel && !d_rmw) || (state_q == ST_RMW);
            d_err_o    <= d_sel && d_oor;
            d_rdata_o  <= (d_sel && !d_oor && !d_we_i) ? ram_dout_i : 32'h0;
        end
    end

endmodule
